joint_unistepper_ctrl: RTL and testbench

Motion sequencer placed in front of a unipolar stepper joint driver (`joint_unistepper_nf`-style: signed half-period command, 0 = stop, enable gates coils). It takes a raw signed period command and a master enable from the host, and issues a slew-limited period command plus a coil enable.
- Sequencing covers coil arming delay, acceleration/deceleration ramps and stop-before-reverse.
- An idle power-save timeout drops coil current when the joint is stationary.

---
 rtl/joint_unistepper_pkg.sv | 42 ++++
 rtl/joint_unistepper_slew.sv | 42 ++++
 rtl/joint_unistepper_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_joint_unistepper_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/joint_unistepper_pkg.sv
// Purpose: shared types and saturating 32-bit magnitude helpers for the joint unistepper sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package joint_unistepper_pkg;

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_ARM  = 3'd1,
        S_IDLE = 3'd2,
        S_RUN  = 3'd3,
        S_SAVE = 3'd4
    } state_t;

    typedef logic [31:0] mag_t;

    localparam mag_t MAG_MAX = 32'hFFFF_FFFF;
    localparam mag_t POS_MAX = 32'h7FFF_FFFF;

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic mag_t sat_add(input mag_t a, input mag_t b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? MAG_MAX : s[31:0];
    endfunction

    // Unsigned subtract that sticks at zero instead of wrapping.
    function automatic mag_t sat_sub(input mag_t a, input mag_t b);
        return (a < b) ? '0 : (a - b);
    endfunction

    // Magnitude of a signed command; -2^31 has no positive twin and clips to 2^31-1.
    function automatic mag_t abs_sat(input logic signed [31:0] v);
        mag_t m;
        m = v[31] ? (~mag_t'(v) + 32'd1) : mag_t'(v);
        // Only -2^31 can still have bit 31 set after negation.
        if (m[31]) begin
            m = POS_MAX;
        end
        return m;
    endfunction

endpackage

// File: rtl/joint_unistepper_slew.sv
// Purpose: one ramp-tick step of the period magnitude toward its target, or toward START_PERIOD when stopping.
// Latency: combinational, 0 cycles; the caller owns all state.
// Backpressure: none; result is only consumed on a ramp tick.
// Ports: cur/tgt current and effective target magnitude, stop = stop request,
//        nxt = magnitude after this tick, done = stop requested and already at the slow end.
module joint_unistepper_slew
    import joint_unistepper_pkg::*;
#(
    parameter mag_t PSTEP        = 32'd100,
    parameter mag_t START_PERIOD = 32'd50000
)(
    input  logic [31:0] cur,
    input  logic [31:0] tgt,
    input  logic        stop,
    output logic [31:0] nxt,
    output logic        done
);

    mag_t up;
    mag_t dn;

    always_comb begin
        up   = sat_add(cur, PSTEP);
        dn   = sat_sub(cur, PSTEP);
        nxt  = cur;
        // The slow-end check uses the magnitude before this tick, so the
        // driver sees START_PERIOD for a full tick before dropping to zero.
        done = stop && (cur >= START_PERIOD);

        if (stop) begin
            nxt = (up > START_PERIOD) ? START_PERIOD : up;
        end else if (tgt >= START_PERIOD) begin
            // Slow targets need no ramp: the motor can start/stop there directly.
            nxt = tgt;
        end else if (cur > tgt) begin
            nxt = (dn < tgt) ? tgt : dn;
        end else if (cur < tgt) begin
            nxt = (up > tgt) ? tgt : up;
        end
    end

endmodule

// File: rtl/joint_unistepper_ctrl.sv
// Purpose: slew-limited period/enable sequencer (arm delay, ramps, stop-before-reverse, idle power save).
// Latency: all outputs registered from the next-state values, so they show the new state right after the transition edge.
// Backpressure: none; cmd_period is sampled every cycle outside RUN and only on ramp ticks inside RUN.
// Ports: clk, rst_n (sync, active-low), enable_in, cmd_period (signed half-period, 0 = stop)
//        -> jointEnable (coil enable), jointFreqCmd (signed slewed period), moving, at_speed.
module joint_unistepper_ctrl
    import joint_unistepper_pkg::*;
#(
    parameter logic [31:0] ARM_CYCLES   = 32'd1000,
    parameter logic [31:0] HOLD_CYCLES  = 32'd50000000,
    parameter logic [31:0] RAMP_DIV     = 32'd1000,
    parameter logic [31:0] PSTEP        = 32'd100,
    parameter logic [31:0] START_PERIOD = 32'd50000,
    parameter logic [31:0] MIN_PERIOD   = 32'd500
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_in,
    input  logic signed [31:0] cmd_period,
    output logic               jointEnable,
    output logic signed [31:0] jointFreqCmd,
    output logic               moving,
    output logic               at_speed
);

    state_t state, nxt_state;
    mag_t   timer, nxt_timer;     // arming countdown
    mag_t   hold,  nxt_hold;      // stationary cycles spent in IDLE
    mag_t   tick,  nxt_tick;      // ramp divider
    mag_t   cur,   nxt_cur;       // current period magnitude
    mag_t   tgt,   nxt_tgt;       // target latched at RUN entry and each tick
    logic   dir,   nxt_dir;       // 1 = positive direction

    mag_t   mag;
    mag_t   tgt_eff;
    logic   cmd_nz;
    logic   stop_req;
    mag_t   slew_nxt;
    logic   slew_done;

    logic               en_d;
    logic signed [31:0] freq_d;
    logic               moving_d;
    logic               at_speed_d;

    always_comb begin
        mag     = abs_sat(cmd_period);
        tgt_eff = (mag < MIN_PERIOD) ? MIN_PERIOD : mag;
        cmd_nz  = (cmd_period != 32'sd0);
        // Sign bit equal to dir means the command points the other way
        // (dir=1 is positive, whose commands have sign bit 0).
        stop_req = !cmd_nz || (cmd_period[31] == dir);
    end

    joint_unistepper_slew #(
        .PSTEP        (PSTEP),
        .START_PERIOD (START_PERIOD)
    ) u_slew (
        .cur  (cur),
        .tgt  (tgt_eff),
        .stop (stop_req),
        .nxt  (slew_nxt),
        .done (slew_done)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_OFF;
            timer <= '0;
            hold  <= '0;
            tick  <= '0;
            cur   <= '0;
            tgt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= nxt_state;
            timer <= nxt_timer;
            hold  <= nxt_hold;
            tick  <= nxt_tick;
            cur   <= nxt_cur;
            tgt   <= nxt_tgt;
            dir   <= nxt_dir;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        nxt_state = state;
        nxt_timer = timer;
        nxt_hold  = '0;
        nxt_tick  = tick;
        nxt_cur   = cur;
        nxt_tgt   = tgt;
        nxt_dir   = dir;

        if (!enable_in) begin
            // Emergency drop: no ramp-down, coils off immediately.
            nxt_state = S_OFF;
            nxt_timer = '0;
            nxt_tick  = '0;
            nxt_cur   = '0;
            nxt_tgt   = '0;
        end else begin
            unique case (state)
                S_OFF: begin
                    nxt_state = S_ARM;
                    nxt_timer = ARM_CYCLES;
                end
                S_ARM: begin
                    // Leave on the edge where the countdown reaches zero,
                    // so ARM lasts ARM_CYCLES cycles (one cycle when zero).
                    if (timer <= 32'd1) begin
                        nxt_state = S_IDLE;
                        nxt_timer = '0;
                    end else begin
                        nxt_timer = timer - 32'd1;
                    end
                end
                S_IDLE: begin
                    // A motion request beats a coincident hold timeout.
                    if (cmd_nz) begin
                        nxt_state = S_RUN;
                        nxt_dir   = ~cmd_period[31];
                        nxt_cur   = (tgt_eff >= START_PERIOD) ? tgt_eff : START_PERIOD;
                        nxt_tgt   = tgt_eff;
                        nxt_tick  = '0;
                    end else if ((HOLD_CYCLES != 32'd0) && (hold == HOLD_CYCLES - 32'd1)) begin
                        nxt_state = S_SAVE;
                    end else begin
                        nxt_hold = hold + 32'd1;
                    end
                end
                S_SAVE: begin
                    // Coils were released, so they must settle again before motion.
                    if (cmd_nz) begin
                        nxt_state = S_ARM;
                        nxt_timer = ARM_CYCLES;
                    end
                end
                S_RUN: begin
                    if (tick == RAMP_DIV - 32'd1) begin
                        nxt_tick = '0;
                        if (slew_done) begin
                            nxt_state = S_IDLE;
                            nxt_cur   = '0;
                            nxt_tgt   = '0;
                        end else begin
                            nxt_cur = slew_nxt;
                            nxt_tgt = stop_req ? START_PERIOD : tgt_eff;
                        end
                    end else begin
                        nxt_tick = tick + 32'd1;
                    end
                end
                default: begin
                    nxt_state = S_OFF;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        en_d       = (nxt_state == S_ARM) || (nxt_state == S_IDLE) || (nxt_state == S_RUN);
        moving_d   = (nxt_state == S_RUN);
        at_speed_d = (nxt_state == S_RUN) && (nxt_cur == nxt_tgt);
        freq_d     = 32'sd0;
        if (nxt_state == S_RUN) begin
            freq_d = nxt_dir ? $signed(nxt_cur) : -$signed(nxt_cur);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            jointEnable  <= 1'b0;
            jointFreqCmd <= 32'sd0;
            moving       <= 1'b0;
            at_speed     <= 1'b0;
        end else begin
            jointEnable  <= en_d;
            jointFreqCmd <= freq_d;
            moving       <= moving_d;
            at_speed     <= at_speed_d;
        end
    end

endmodule

// File: tb/tb_joint_unistepper_ctrl.sv
// Purpose: self-checking bench for joint_unistepper_ctrl; expected output changes are queued with their cycle stamps.
// Latency: n/a.
// Backpressure: n/a.
module tb_joint_unistepper_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable_in;
    logic signed [31:0] cmd_period;
    logic               jointEnable;
    logic signed [31:0] jointFreqCmd;
    logic               moving;
    logic               at_speed;

    joint_unistepper_ctrl #(
        .ARM_CYCLES   (32'd10),
        .HOLD_CYCLES  (32'd20),
        .RAMP_DIV     (32'd4),
        .PSTEP        (32'd100),
        .START_PERIOD (32'd1000),
        .MIN_PERIOD   (32'd200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_in    (enable_in),
        .cmd_period   (cmd_period),
        .jointEnable  (jointEnable),
        .jointFreqCmd (jointFreqCmd),
        .moving       (moving),
        .at_speed     (at_speed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int   cyc;
        logic en;
        int   freq;
    } ev_t;

    ev_t exp_q[$];

    task automatic push(input int c, input logic e, input int f);
        ev_t ev;
        ev.cyc  = c;
        ev.en   = e;
        ev.freq = f;
        exp_q.push_back(ev);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Every change of (jointEnable, jointFreqCmd) must match the next queued event.
    logic               mon_on = 1'b0;
    logic               last_en;
    logic signed [31:0] last_freq;

    always @(negedge clk) begin
        if (mon_on && ((jointEnable !== last_en) || (jointFreqCmd !== last_freq))) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_event_cyc", cyc, -1);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_cyc", cyc, e.cyc);
                chk("ev_en", jointEnable, e.en);
                chk("ev_freq", jointFreqCmd, e.freq);
            end
            last_en   = jointEnable;
            last_freq = jointFreqCmd;
        end
    end

    int t;
    int e1;
    int e2;
    int u;

    initial begin
        rst_n      = 1'b0;
        enable_in  = 1'b0;
        cmd_period = 32'sd0;
        repeat (3) @(negedge clk);
        chk("rst_en", jointEnable, 0);
        chk("rst_freq", jointFreqCmd, 0);
        chk("rst_moving", moving, 0);
        chk("rst_at_speed", at_speed, 0);
        rst_n = 1'b1;
        @(negedge clk);
        last_en   = 1'b0;
        last_freq = 32'sd0;
        mon_on    = 1'b1;

        // Power-up: arm delay, start at START_PERIOD, ramp down to +500.
        t          = cyc;
        enable_in  = 1'b1;
        cmd_period = 32'sd500;
        push(t + 1, 1'b1, 0);
        push(t + 12, 1'b1, 1000);
        for (int k = 1; k <= 5; k++) push(t + 12 + 4 * k, 1'b1, 1000 - 100 * k);
        wait_to(t + 31);
        chk("pu_moving", moving, 1);
        chk("pu_not_at_speed", at_speed, 0);
        wait_to(t + 32);
        chk("pu_at_speed", at_speed, 1);

        // Reversal: ramp up to START, one cycle at zero, then ramp the other way.
        e1 = t + 12;
        wait_to(e1 + 22);
        cmd_period = -32'sd500;
        for (int k = 1; k <= 5; k++) push(e1 + 20 + 4 * k, 1'b1, 500 + 100 * k);
        push(e1 + 44, 1'b1, 0);
        e2 = e1 + 45;
        push(e2, 1'b1, -1000);
        for (int k = 1; k <= 5; k++) push(e2 + 4 * k, 1'b1, -1000 + 100 * k);
        wait_to(e1 + 43);
        chk("rev_at_start_at_speed", at_speed, 1);
        wait_to(e1 + 44);
        chk("rev_idle_moving", moving, 0);
        wait_to(e2 + 20);
        chk("rev_at_speed", at_speed, 1);

        // Clamp: -50 is faster than MIN, so the ramp stops at -200.
        wait_to(e2 + 22);
        cmd_period = -32'sd50;
        push(e2 + 24, 1'b1, -400);
        push(e2 + 28, 1'b1, -300);
        push(e2 + 32, 1'b1, -200);
        wait_to(e2 + 33);
        chk("clamp_at_speed", at_speed, 1);

        // Emergency: drop enable mid-ramp.
        wait_to(e2 + 42);
        cmd_period = -32'sd900;
        push(e2 + 44, 1'b1, -300);
        wait_to(e2 + 45);
        enable_in = 1'b0;
        push(e2 + 46, 1'b0, 0);
        wait_to(e2 + 46);
        chk("emerg_moving", moving, 0);
        chk("emerg_at_speed", at_speed, 0);
        wait_to(e2 + 50);

        // Power save, re-arm from SAVE, slow command goes straight to +5000.
        u          = cyc;
        enable_in  = 1'b1;
        cmd_period = 32'sd0;
        push(u + 1, 1'b1, 0);
        push(u + 31, 1'b0, 0);
        wait_to(u + 35);
        cmd_period = 32'sd5000;
        push(u + 36, 1'b1, 0);
        push(u + 47, 1'b1, 5000);
        wait_to(u + 47);
        chk("slow_at_speed", at_speed, 1);
        chk("slow_moving", moving, 1);

        // Reset in RUN.
        wait_to(u + 50);
        rst_n = 1'b0;
        push(u + 51, 1'b0, 0);
        wait_to(u + 51);
        chk("rst_run_moving", moving, 0);
        chk("rst_run_at_speed", at_speed, 0);
        wait_to(u + 52);
        rst_n = 1'b1;
        push(u + 53, 1'b1, 0);
        wait_to(u + 56);
        enable_in = 1'b0;
        push(u + 57, 1'b0, 0);
        wait_to(u + 60);

        chk("sb_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
